// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID instruction FIFO presenting pre-split decode fields at the head
// Define IF_ID_QUEUE_BYPASS_EN for a same-cycle input-to-output path while the queue is empty.
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [PC_W-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [15:0]            out_imm16,
   output logic [4:0]             out_rs,
   output logic [4:0]             out_rt,
   output logic [4:0]             out_rd,
   output logic [PC_W-1:0]        out_pc,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]     instr_mem [DEPTH];
   logic [PC_W-1:0] pc_mem    [DEPTH];

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic            queue_valid;
   logic            bypass;
   logic            push;
   logic            pop;
   logic            wr_en;
   logic            rd_en;
   logic [31:0]     head_instr;
   logic [PC_W-1:0] head_pc;

   assign queue_valid = (count_q != '0) && !flush_i;
   assign in_ready    = (count_q < FULL) && !flush_i;

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign bypass = (count_q == '0) && in_valid && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = queue_valid || bypass;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // A bypassed instruction taken by decode in the same cycle never enters storage
   assign wr_en     = push && !(bypass && out_ready);
   assign rd_en     = pop && !bypass;

   always_comb begin
      head_instr = instr_mem[rd_ptr_q];
      head_pc    = pc_mem[rd_ptr_q];
      if (bypass) begin
         head_instr = in_instr;
         head_pc    = in_pc;
      end
   end

   assign out_instr = out_valid ? head_instr : 32'd0;
   assign out_pc    = out_valid ? head_pc : '0;
   assign out_imm16 = out_instr[15:0];
   assign out_rs    = out_instr[25:21];
   assign out_rt    = out_instr[20:16];
   assign out_rd    = out_instr[15:11];
   assign count_o   = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_mem[wr_ptr_q] <= in_instr;
         pc_mem[wr_ptr_q]    <= in_pc;
      end
   end
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue-based model
module tb_if_id_queue;
   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            flush_i = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [31:0]     in_instr = '0;
   logic [PC_W-1:0] in_pc = '0;
   logic            in_ready;
   logic            out_valid;
   logic [31:0]     out_instr;
   logic [15:0]     out_imm16;
   logic [4:0]      out_rs;
   logic [4:0]      out_rt;
   logic [4:0]      out_rd;
   logic [PC_W-1:0] out_pc;
   logic [CW-1:0]   count_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [PC_W+31:0] mq[$];
   logic [31:0] fill [4] = '{32'h012A4020, 32'h01095022, 32'h8D280004, 32'hAD2A0008};

   if_id_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_imm16(out_imm16), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_pc(out_pc), .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic bypass_now();
`ifdef IF_ID_QUEUE_BYPASS_EN
      return (mq.size() == 0) && in_valid && !flush_i;
`else
      return 1'b0;
`endif
   endfunction

   // Model update: reset/flush empty it, bypass-consume leaves it alone, else pop then push
   always @(posedge clk or negedge rst) begin
      logic byp, ev, push, pop;
      if (!rst || flush_i) begin
         mq.delete();
      end else begin
         byp  = bypass_now();
         ev   = (mq.size() != 0) || byp;
         push = in_valid && (mq.size() < DEPTH);
         pop  = ev && out_ready;
         if (!(byp && out_ready)) begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({in_pc, in_instr});
         end
      end
   end

   always @(negedge clk) begin
      logic byp, ev;
      logic [31:0] ei;
      logic [PC_W-1:0] ep;
      byp = bypass_now();
      ev  = ((mq.size() != 0) && !flush_i) || byp;
      ei  = '0;
      ep  = '0;
      if (byp) begin
         ei = in_instr;
         ep = in_pc;
      end else if (ev) begin
         ei = mq[0][31:0];
         ep = mq[0][PC_W+31:32];
      end
      chk("model.in_ready", 64'(in_ready), 64'((mq.size() < DEPTH) && !flush_i));
      chk("model.out_valid", 64'(out_valid), 64'(ev));
      chk("model.count", 64'(count_o), 64'(mq.size()));
      chk("model.instr", 64'(out_instr), 64'(ei));
      chk("model.pc", 64'(out_pc), 64'(ep));
      chk("model.imm16", 64'(out_imm16), 64'(ei[15:0]));
      chk("model.rs", 64'(out_rs), 64'(ei[25:21]));
      chk("model.rt", 64'(out_rt), 64'(ei[20:16]));
      chk("model.rd", 64'(out_rd), 64'(ei[15:11]));
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.count", 64'(count_o), 64'(0));
      chk("reset.out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1 rst = 1'b1;

      // field split
      in_valid = 1'b1; in_instr = 32'h8C2A0010; in_pc = 32'hBFC00000; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("split.valid", 64'(out_valid), 64'(1));
      chk("split.rs", 64'(out_rs), 64'(1));
      chk("split.rt", 64'(out_rt), 64'(10));
      chk("split.rd", 64'(out_rd), 64'(0));
      chk("split.imm16", 64'(out_imm16), 64'(16'h0010));
      chk("split.pc", 64'(out_pc), 64'(32'hBFC00000));
      @(posedge clk); #1 out_ready = 1'b0;

      // fill to full, fifth offer must be ignored
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_instr = fill[k]; in_pc = 32'h1000 + 32'(4 * k);
         @(posedge clk); #1;
      end
      in_instr = 32'hDEADBEEF; in_pc = 32'h2000;
      @(negedge clk);
      chk("full.count", 64'(count_o), 64'(4));
      chk("full.in_ready", 64'(in_ready), 64'(0));
      chk("full.head_rs", 64'(out_rs), 64'(9));
      chk("full.head_rd", 64'(out_rd), 64'(8));
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("drain.instr", 64'(out_instr), 64'(fill[k]));
         chk("drain.count", 64'(count_o), 64'(4 - k));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("drain.empty_valid", 64'(out_valid), 64'(0));
      chk("drain.empty_instr", 64'(out_instr), 64'(0));
      chk("drain.empty_count", 64'(count_o), 64'(0));

      // concurrent push/pop at count 2, pointers wrap
      @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_instr = 32'hC0000000 + 32'(k); in_pc = 32'h3000 + 32'(4 * k);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int k = 2; k < 8; k++) begin
         in_instr = 32'hC0000000 + 32'(k); in_pc = 32'h3000 + 32'(4 * k);
         @(negedge clk);
         chk("conc.count", 64'(count_o), 64'(2));
         chk("conc.instr", 64'(out_instr), 64'(32'hC0000000 + 32'(k - 2)));
         @(posedge clk); #1;
      end
      out_ready = 1'b0; in_instr = 32'hC0000008; in_pc = 32'h3020;
      @(posedge clk); #1;

      // flush with three entries and a concurrent push offer
      flush_i = 1'b1; in_valid = 1'b1; in_instr = 32'h0000F00D; out_ready = 1'b1;
      @(negedge clk);
      chk("flush.pre_count", 64'(count_o), 64'(3));
      chk("flush.in_ready", 64'(in_ready), 64'(0));
      chk("flush.out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1 flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("flush.count", 64'(count_o), 64'(0));
      chk("flush.after_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1 in_valid = 1'b1; in_instr = 32'hA5A50001; in_pc = 32'h4000;
      @(posedge clk); #1 in_instr = 32'hA5A50002; in_pc = 32'h4004;
      @(negedge clk);
      chk("post_flush.instr", 64'(out_instr), 64'(32'hA5A50001));
      chk("post_flush.count", 64'(count_o), 64'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst.count", 64'(count_o), 64'(2));

      // asynchronous reset between edges
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("rst.count", 64'(count_o), 64'(0));
      chk("rst.out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("rst.in_ready", 64'(in_ready), 64'(1));

`ifdef IF_ID_QUEUE_BYPASS_EN
      @(posedge clk); #1 in_valid = 1'b1; in_instr = 32'h24080005; in_pc = 32'h5000; out_ready = 1'b1;
      #1;
      chk("byp.valid", 64'(out_valid), 64'(1));
      chk("byp.instr", 64'(out_instr), 64'(32'h24080005));
      chk("byp.count", 64'(count_o), 64'(0));
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk("byp.count_taken", 64'(count_o), 64'(0));
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("byp.count_stored", 64'(count_o), 64'(1));
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
